// File: rtl/atm_core_param_if.sv
// atm_core_param_if: front-panel strobes in, display/status out.
// master = panel/decoder side, slave = ATM core side.
interface atm_core_param_if #(
    parameter int ACC_W = 12,
    parameter int PIN_W = 4,
    parameter int BAL_W = 16
);
    logic             card_valid;
    logic [ACC_W-1:0] acc_number;
    logic             pin_valid;
    logic [PIN_W-1:0] pin;
    logic             op_valid;
    logic [2:0]       menu_option;
    logic [BAL_W-1:0] amount;
    logic [ACC_W-1:0] dest_acc;
    logic             exit;
    logic             op_done;
    logic             error;
    logic [BAL_W-1:0] balance;
    logic             session_active;
    logic             locked;
    logic             timeout;

    modport master (
        output card_valid, acc_number, pin_valid, pin, op_valid,
        output menu_option, amount, dest_acc, exit,
        input  op_done, error, balance, session_active, locked, timeout
    );

    modport slave (
        input  card_valid, acc_number, pin_valid, pin, op_valid,
        input  menu_option, amount, dest_acc, exit,
        output op_done, error, balance, session_active, locked, timeout
    );
endinterface

// File: rtl/atm_core_param.sv
// atm_core_param: multi-account ATM core (lookup, PIN lockout, menu ops).
// Build macro ATM_SESSION_LIMIT_EN adds a per-session debit cap.
module atm_core_param #(
    parameter int NUM_ACCOUNTS   = 16,
    parameter int ACC_W          = 12,
    parameter int PIN_W          = 4,
    parameter int BAL_W          = 16,
    parameter int ACC_BASE       = 2170,
    parameter int INIT_BAL       = 1000,
    parameter int MAX_PIN_TRIES  = 3,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int SESSION_LIMIT  = 1500
) (
    input logic             clk,
    input logic             rst,
    atm_core_param_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_ACCOUNTS);
    localparam int TRY_W = $clog2(MAX_PIN_TRIES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, AUTH, MENU} state_t;

    state_t            state_q, state_d;
    logic [BAL_W-1:0]  bal_q   [NUM_ACCOUNTS];
    logic [TRY_W-1:0]  tries_q [NUM_ACCOUNTS];
    logic [NUM_ACCOUNTS-1:0] lock_q;
    logic [IDX_W-1:0]  cur_q;
    logic [TO_W-1:0]   tcnt_q;
    logic [BAL_W-1:0]  disp_q;
    logic done_q, err_q, locked_q, to_q;
    logic done_d, err_d, lock_d, to_d;
    logic wd_ok, xfer_ok, dep_ok;

    // Account numbers are fixed at ACC_BASE+slot; lowest match wins.
    function automatic logic [IDX_W:0] lookup(input logic [ACC_W-1:0] num);
        logic [IDX_W:0] r;
        r = '0;
        for (int i = NUM_ACCOUNTS - 1; i >= 0; i--)
            if (num == ACC_W'(ACC_BASE + i)) r = {1'b1, IDX_W'(i)};
        return r;
    endfunction

    logic             card_hit, dest_hit;
    logic [IDX_W-1:0] card_idx, dest_idx;
    logic [BAL_W-1:0] own_bal, dst_bal;
    logic [BAL_W:0]   dep_sum, xfer_sum;
    logic             funds_ok, pin_ok, lim_ok;

    assign {card_hit, card_idx} = lookup(bus.acc_number);
    assign {dest_hit, dest_idx} = lookup(bus.dest_acc);
    assign own_bal  = bal_q[cur_q];
    assign dst_bal  = bal_q[dest_idx];
    assign dep_sum  = {1'b0, own_bal} + {1'b0, bus.amount};
    assign xfer_sum = {1'b0, dst_bal} + {1'b0, bus.amount};
    assign funds_ok = bus.amount <= own_bal;
    assign pin_ok   = bus.pin == PIN_W'(cur_q);

`ifdef ATM_SESSION_LIMIT_EN
    logic [BAL_W:0]   sess_q;
    logic [BAL_W+1:0] sess_sum;
    assign sess_sum = {1'b0, sess_q} + {2'b00, bus.amount};
    assign lim_ok   = sess_sum <= (BAL_W+2)'(SESSION_LIMIT);
`else
    assign lim_ok = 1'b1;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state, step result and which table update to perform.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        lock_d  = 1'b0;
        to_d    = 1'b0;
        wd_ok   = 1'b0;
        xfer_ok = 1'b0;
        dep_ok  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.card_valid) begin
                    done_d = 1'b1;
                    if (card_hit && !lock_q[card_idx]) state_d = AUTH;
                    else                               err_d   = 1'b1;
                end
            end
            AUTH: begin
                if (bus.exit) begin
                    state_d = IDLE;
                end else if (bus.pin_valid) begin
                    done_d = 1'b1;
                    if (pin_ok) begin
                        state_d = MENU;
                    end else begin
                        err_d = 1'b1;
                        if (int'(tries_q[cur_q]) + 1 >= MAX_PIN_TRIES) begin
                            lock_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
            end
            MENU: begin
                if (bus.exit) begin
                    state_d = IDLE;
                end else if (bus.op_valid) begin
                    done_d = 1'b1;
                    unique case (bus.menu_option)
                        3'b100, 3'b101: wd_ok = funds_ok && lim_ok;
                        3'b110: xfer_ok = dest_hit && dest_idx != cur_q &&
                                          !lock_q[dest_idx] && funds_ok &&
                                          !xfer_sum[BAL_W] && lim_ok;
                        3'b111: dep_ok = !dep_sum[BAL_W];
                        default: ;
                    endcase
                    err_d = !(bus.menu_option == 3'b011 ||
                              wd_ok || xfer_ok || dep_ok);
                end else if (int'(tcnt_q) >= TIMEOUT_CYCLES - 1) begin
                    to_d    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Account table: balances, PIN try counters, lock flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_ACCOUNTS; i++) begin
                bal_q[i]   <= BAL_W'(INIT_BAL);
                tries_q[i] <= '0;
            end
            lock_q <= '0;
        end else begin
            if (wd_ok || xfer_ok) bal_q[cur_q]    <= own_bal - bus.amount;
            if (xfer_ok)          bal_q[dest_idx] <= xfer_sum[BAL_W-1:0];
            if (dep_ok)           bal_q[cur_q]    <= dep_sum[BAL_W-1:0];
            if (state_q == AUTH && done_d) begin
                if (!err_d) begin
                    tries_q[cur_q] <= '0;
                end else if (lock_d) begin
                    tries_q[cur_q] <= TRY_W'(MAX_PIN_TRIES);
                    lock_q[cur_q]  <= 1'b1;
                end else begin
                    tries_q[cur_q] <= tries_q[cur_q] + TRY_W'(1);
                end
            end
        end
    end

    // Session registers: active slot, display balance, idle count, pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_q    <= '0;
            tcnt_q   <= '0;
            disp_q   <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            locked_q <= 1'b0;
            to_q     <= 1'b0;
`ifdef ATM_SESSION_LIMIT_EN
            sess_q   <= '0;
`endif
        end else begin
            done_q   <= done_d;
            err_q    <= err_d;
            locked_q <= lock_d;
            to_q     <= to_d;
            if (state_q == IDLE && state_d == AUTH) cur_q <= card_idx;
            if (state_d != MENU || state_q != MENU || bus.op_valid)
                tcnt_q <= '0;
            else
                tcnt_q <= tcnt_q + TO_W'(1);
            if (state_d != MENU)       disp_q <= '0;
            else if (state_q == AUTH)  disp_q <= own_bal;
            else if (wd_ok || xfer_ok) disp_q <= own_bal - bus.amount;
            else if (dep_ok)           disp_q <= dep_sum[BAL_W-1:0];
`ifdef ATM_SESSION_LIMIT_EN
            if (state_q != MENU)       sess_q <= '0;
            else if (wd_ok || xfer_ok) sess_q <= sess_sum[BAL_W:0];
`endif
        end
    end

    assign bus.op_done        = done_q;
    assign bus.error          = err_q;
    assign bus.balance        = disp_q;
    assign bus.session_active = state_q != IDLE;
    assign bus.locked         = locked_q;
    assign bus.timeout        = to_q;
endmodule

// File: tb/tb_atm_core_param.sv
// tb_atm_core_param: directed plan steps plus random sessions,
// checked against an account-level model kept in the bench.
module tb_atm_core_param;
    localparam int NUM   = 16;
    localparam int ACC_W = 12;
    localparam int PIN_W = 4;
    localparam int BAL_W = 16;
    localparam int BASE  = 2170;
    localparam int INIT  = 1000;
    localparam int TRIES = 3;
    localparam int TOUT  = 64;
    localparam int LIMIT = 1500;
    localparam int BMAX  = 65535;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_tests = 0;
    int n_fail  = 0;

    atm_core_param_if #(.ACC_W(ACC_W), .PIN_W(PIN_W), .BAL_W(BAL_W)) bus ();

    atm_core_param #(
        .NUM_ACCOUNTS(NUM), .ACC_W(ACC_W), .PIN_W(PIN_W), .BAL_W(BAL_W),
        .ACC_BASE(BASE), .INIT_BAL(INIT), .MAX_PIN_TRIES(TRIES),
        .TIMEOUT_CYCLES(TOUT), .SESSION_LIMIT(LIMIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Model: 0 = no card, 1 = waiting for PIN, 2 = in menu.
    int m_state;
    int m_cur;
    int m_sess;
    int m_bal   [NUM];
    int m_tries [NUM];
    bit m_lock  [NUM];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_cur   = 0;
        m_sess  = 0;
        for (int i = 0; i < NUM; i++) begin
            m_bal[i]   = INIT;
            m_tries[i] = 0;
            m_lock[i]  = 1'b0;
        end
    endtask

    function automatic bit under_limit(input int amt);
`ifdef ATM_SESSION_LIMIT_EN
        return m_sess + amt <= LIMIT;
`else
        return amt >= 0;
`endif
    endfunction

    function automatic bit apply_op(input int opt, input int amt, input int dst);
        int d;
        d = dst - BASE;
        case (opt)
            3: return 1'b1;
            4, 5: begin
                if (amt > m_bal[m_cur] || !under_limit(amt)) return 1'b0;
                m_bal[m_cur] -= amt;
                m_sess += amt;
                return 1'b1;
            end
            6: begin
                if (d < 0 || d >= NUM || d == m_cur || m_lock[d]) return 1'b0;
                if (amt > m_bal[m_cur] || m_bal[d] + amt > BMAX) return 1'b0;
                if (!under_limit(amt)) return 1'b0;
                m_bal[m_cur] -= amt;
                m_bal[d] += amt;
                m_sess += amt;
                return 1'b1;
            end
            7: begin
                if (m_bal[m_cur] + amt > BMAX) return 1'b0;
                m_bal[m_cur] += amt;
                return 1'b1;
            end
            default: return 1'b0;
        endcase
    endfunction

    task automatic clear_inputs();
        bus.card_valid  = 1'b0;
        bus.acc_number  = '0;
        bus.pin_valid   = 1'b0;
        bus.pin         = '0;
        bus.op_valid    = 1'b0;
        bus.menu_option = '0;
        bus.amount      = '0;
        bus.dest_acc    = '0;
        bus.exit        = 1'b0;
    endtask

    // One input cycle; model predicts the registered result.
    task automatic step(input bit cv, input int acc, input bit pv, input int p,
                        input bit ov, input int opt, input int amt,
                        input int dst, input bit ex);
        bit e_done, e_err, e_lock;
        int idx;
        e_done = 0;
        e_err  = 0;
        e_lock = 0;
        acc = acc % (1 << ACC_W);
        dst = dst % (1 << ACC_W);
        p   = p % (1 << PIN_W);
        amt = amt % (BMAX + 1);
        @(negedge clk);
        bus.card_valid  = cv;
        bus.acc_number  = ACC_W'(acc);
        bus.pin_valid   = pv;
        bus.pin         = PIN_W'(p);
        bus.op_valid    = ov;
        bus.menu_option = 3'(opt);
        bus.amount      = BAL_W'(amt);
        bus.dest_acc    = ACC_W'(dst);
        bus.exit        = ex;
        if (m_state == 0) begin
            if (cv) begin
                e_done = 1;
                idx = acc - BASE;
                if (idx >= 0 && idx < NUM && !m_lock[idx]) begin
                    m_cur = idx;
                    m_state = 1;
                end else begin
                    e_err = 1;
                end
            end
        end else if (ex) begin
            m_state = 0;
        end else if (m_state == 1) begin
            if (pv) begin
                e_done = 1;
                if (p == m_cur % 16) begin
                    m_tries[m_cur] = 0;
                    m_sess = 0;
                    m_state = 2;
                end else begin
                    e_err = 1;
                    m_tries[m_cur]++;
                    if (m_tries[m_cur] >= TRIES) begin
                        m_lock[m_cur] = 1'b1;
                        e_lock = 1;
                        m_state = 0;
                    end
                end
            end
        end else if (ov) begin
            e_done = 1;
            e_err = !apply_op(opt, amt, dst);
        end
        @(posedge clk);
        #1;
        clear_inputs();
        check("op_done", bus.op_done, e_done);
        if (e_done) check("error", bus.error, e_err);
        check("locked", bus.locked, e_lock);
        check("timeout", bus.timeout, 0);
        check("session_active", bus.session_active, m_state != 0);
        check("balance", bus.balance, m_state == 2 ? m_bal[m_cur] : 0);
    endtask

    task automatic card(input int acc);
        step(1, acc, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic enter_pin(input int p);
        step(0, 0, 1, p, 0, 0, 0, 0, 0);
    endtask
    task automatic op(input int opt, input int amt, input int dst);
        step(0, 0, 0, 0, 1, opt, amt, dst, 0);
    endtask
    task automatic leave();
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask
    task automatic idle_cycle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        model_reset();
        @(posedge clk);
        #1;
        check("rst_op_done", bus.op_done, 0);
        check("rst_error", bus.error, 0);
        check("rst_balance", bus.balance, 0);
        check("rst_session", bus.session_active, 0);
        check("rst_locked", bus.locked, 0);
        check("rst_timeout", bus.timeout, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic login(input int acc);
        card(acc);
        enter_pin((acc - BASE) % 16);
    endtask

    task automatic wait_timeout();
        int n;
        bit seen;
        n = 0;
        seen = 0;
        while (!seen && n < 4 * TOUT) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.timeout) seen = 1;
        end
        check("timeout_cycles", n, TOUT);
        m_state = 0;
        check("timeout_balance", bus.balance, 0);
        check("timeout_session", bus.session_active, 0);
        @(posedge clk);
        #1;
        check("timeout_pulse_width", bus.timeout, 0);
    endtask

    initial begin
        int r, amt, opt;
        clear_inputs();
        model_reset();
        do_reset();

        login(2178);
        op(3, 0, 0);
        check("plan_bal_1000", bus.balance, 1000);
        check("plan_bal_err", bus.error, 0);
        op(7, 250, 0);
        check("plan_dep_1250", bus.balance, 1250);

        do_reset();
        login(2178);
        check("plan_table_restored", bus.balance, 1000);
        op(4, 1001, 0);
        check("plan_overdraw_err", bus.error, 1);
        check("plan_overdraw_bal", bus.balance, 1000);
        op(5, 1000, 0);
        check("plan_wd_all", bus.balance, 0);

        do_reset();
        login(2178);
        op(6, 300, 2179);
        check("plan_xfer_src", bus.balance, 700);
        op(6, 10, 2178);
        check("plan_xfer_self", bus.error, 1);
        op(6, 10, 9999);
        check("plan_xfer_nodest", bus.error, 1);
        leave();
        login(2179);
        check("plan_xfer_dst", bus.balance, 1300);
        leave();

        card(2180);
        enter_pin(0);
        enter_pin(1);
        enter_pin(2);
        check("plan_lock_pulse", bus.locked, 1);
        check("plan_lock_idle", bus.session_active, 0);
        card(2180);
        check("plan_locked_card", bus.error, 1);
        do_reset();
        login(2180);
        check("plan_unlock_rst", bus.session_active, 1);

        wait_timeout();

        login(2180);
        step(0, 0, 0, 0, 1, 7, 100, 0, 1);
        login(2180);
        check("plan_exit_beats_op", bus.balance, 1000);
        leave();

        login(2175);
        op(7, 2000, 0);
        op(4, 1000, 0);
        op(4, 600, 0);
`ifdef ATM_SESSION_LIMIT_EN
        check("plan_limit_err", bus.error, 1);
        check("plan_limit_bal", bus.balance, 2000);
`else
        check("plan_nolimit_err", bus.error, 0);
        check("plan_nolimit_bal", bus.balance, 1400);
`endif

        card(2170);
        step(0, 0, 1, 5, 0, 0, 0, 0, 0);
        leave();
        step(0, 0, 1, 0, 1, 7, 5, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);

        for (int k = 0; k < 500; k++) begin
            r = $urandom_range(0, 99);
            if (m_state == 0) begin
                if (r < 85)      card(BASE - 2 + $urandom_range(0, NUM + 3));
                else if (r < 97) step(0, 0, 1, $urandom_range(0, 15), 1,
                                      $urandom_range(0, 7), 5, BASE, 0);
                else             do_reset();
            end else if (m_state == 1) begin
                if (r < 70)      enter_pin(m_cur % 16);
                else if (r < 92) enter_pin($urandom_range(0, 15));
                else if (r < 96) leave();
                else             step(0, 0, 1, m_cur % 16, 0, 0, 0, 0, 1);
            end else begin
                case ($urandom_range(0, 3))
                    0:       amt = $urandom_range(0, 60);
                    1:       amt = m_bal[m_cur] + $urandom_range(0, 2) - 1;
                    2:       amt = $urandom_range(0, BMAX);
                    default: amt = 0;
                endcase
                if (amt < 0) amt = 0;
                opt = $urandom_range(0, 7);
                if (r < 5)       leave();
                else if (r < 9)  step(0, 0, 0, 0, 1, opt, amt, BASE, 1);
                else if (r < 12) step(1, BASE, 1, m_cur % 16, 0, 0, 0, 0, 0);
                else             op(opt, amt, BASE - 1 + $urandom_range(0, NUM + 1));
            end
            repeat ($urandom_range(0, 2)) idle_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/atm_core_param.md
Name: atm_core_param

Overview:
- Parametrised ATM controller core; successor to the fixed single-account ATM.
- Holds an on-chip table of NUM_ACCOUNTS accounts: number, PIN and balance.
- Runs card lookup, PIN authentication with lockout, and a transaction menu: balance, withdraw, transfer, deposit.
- Uses a valid/done handshake and an inactivity timeout. Sits between the front-panel input decoder and the display driver.

Parameters:
- NUM_ACCOUNTS, 16, number of account slots (2..64)
- ACC_W, 12, account-number width
- PIN_W, 4, PIN width
- BAL_W, 16, balance/amount width (unsigned)
- ACC_BASE, 2170, account number of slot 0; slot i = ACC_BASE+i
- INIT_BAL, 1000, reset balance of every slot
- MAX_PIN_TRIES, 3, wrong PINs before lockout
- TIMEOUT_CYCLES, 64, idle MENU cycles before forced session end
- SESSION_LIMIT, 1500, per-session debit cap (optional feature only)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- card_valid  in  1  one-cycle strobe; acc_number valid
- acc_number  in  ACC_W  card account number
- pin_valid  in  1  one-cycle strobe; pin valid
- pin  in  PIN_W  entered PIN
- op_valid  in  1  one-cycle strobe; menu_option/amount/dest_acc valid
- menu_option  in  3  011 balance, 100 withdraw, 101 withdraw+show, 110 transfer, 111 deposit
- amount  in  BAL_W  transaction amount
- dest_acc  in  ACC_W  transfer destination
- exit  in  1  end session
- op_done  out  1  one-cycle pulse; op/PIN/card step completed
- error  out  1  registered; high with op_done when the step failed
- balance  out  BAL_W  current account balance; 0 outside session
- session_active  out  1  high in AUTH/MENU
- locked  out  1  one-cycle pulse when an account gets locked
- timeout  out  1  one-cycle pulse on inactivity exit

Behaviour:
- Reset (async, any state): state IDLE; all outputs 0; slot i gets number ACC_BASE+i, PIN i mod 2^PIN_W, balance INIT_BAL, try count 0, lock flag clear.
- States: IDLE, AUTH, MENU (2-bit encoding suffices).
- IDLE, card_valid: lowest matching slot searched combinationally; result next cycle.
  - Match and unlocked: index latched, go AUTH, op_done=1, error=0.
  - No match or slot locked: stay IDLE, op_done=1, error=1.
- AUTH, pin_valid:
  - Correct PIN: try count cleared, go MENU, balance=slot balance, op_done=1.
  - Wrong PIN: try count +1, op_done=1, error=1. When the count reaches MAX_PIN_TRIES: lock flag set, locked pulse, go IDLE.
- MENU, op_valid: executes in the sampling cycle. Table, balance, op_done and error are all updated on the next edge (latency 1).
  - 011: no change.
  - 100/101: require amount <= balance; debit. Both codes update the balance output.
  - 110: require dest found, dest != own slot, dest unlocked, amount <= balance, and dest balance+amount <= 2^BAL_W-1. Debit own slot, credit dest, same edge.
  - 111: require balance+amount <= 2^BAL_W-1, computed at BAL_W+1 bits; credit.
  - Codes 000/001/010, or any failed requirement: error=1, table unchanged.
- amount=0 is legal for every op.
- Timeout: counter clears on every op_valid and on MENU entry. Reaching TIMEOUT_CYCLES goes to IDLE with a timeout pulse and balance=0.
- exit in AUTH/MENU: IDLE next edge, balance=0, session_active=0. Exit beats a same-cycle op_valid/pin_valid; the op is discarded and no op_done is issued.
- Ignored strobes: card_valid outside IDLE, pin_valid outside AUTH, op_valid outside MENU. None of them produce op_done.
- Lock flags persist across sessions until rst. The try count resets on successful auth only.
- Reset mid-transaction restores the entire table to reset values.

Optional Feature:
- Macro ATM_SESSION_LIMIT_EN.
- Defined:
  - Session debit accumulator (BAL_W+1 bits) cleared on MENU entry.
  - Withdraw/transfer also require accumulator+amount <= SESSION_LIMIT, else error=1.
  - Successful debits add amount to the accumulator; deposits do not reduce it.
- Undefined: no accumulator, no limit check, SESSION_LIMIT unused.

Test Plan:
- card 2178 (slot 8), pin 4'b1000, op 011 -> error=0, balance=1000; op 111 amount 250 -> balance=1250 one cycle later.
- Session on 2178, op 100 amount 1001 -> error=1, balance stays 1000; op 101 amount 1000 -> balance=0.
- Transfer 2178->2179 amount 300 -> balance=700; exit; login 2179 pin 4'b1001 -> balance=1300. Transfer to 2178 itself or to 9999 -> error=1.
- Card 2180, three wrong PINs -> error on each, locked pulse on third, IDLE. Re-insert 2180 -> error=1, stays IDLE. Correct PIN after reset -> MENU.
- MENU idle 64 cycles -> timeout pulse, balance=0. Same-cycle exit+op_valid deposit 100 -> no op_done, balance unchanged at next login.
- ATM_SESSION_LIMIT_EN with INIT_BAL raised to 3000: withdraw 1000 then 600 -> second error=1, balance=2000. Undefined: both succeed, balance=1400.
